// File: rtl/barrel_spawner_pkg.sv
// barrel_spawner_pkg: shared barrel/spawner encodings and LFSR constants
package barrel_spawner_pkg;
    typedef enum logic [1:0] {
        B_INITIAL = 2'b00,
        B_ROLLING = 2'b01,
        B_FALLING = 2'b10
    } barrel_state_e;
    typedef enum logic [1:0] {
        SP_IDLE    = 2'd0,
        SP_WAIT    = 2'd1,
        SP_THROW   = 2'd2,
        SP_RELEASE = 2'd3
    } sp_state_e;
    localparam int LFSR_W = 16;
    // taps 16,14,13,11 as a mask over q[15:0]
    localparam logic [LFSR_W-1:0] LFSR_TAPS     = 16'hB400;
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 16'hACE1;
endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, shifts every non-reset edge
module lfsr16 import barrel_spawner_pkg::*; #(
    parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEF
) (
    input  logic              clk,
    input  logic              rst,
    output logic [LFSR_W-1:0] q
);
    always_ff @(posedge clk)
        q <= rst ? SEED : {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
endmodule

// File: rtl/barrel_spawner.sv
// barrel_spawner: times Kong's throws and launches one free barrel per throw
module barrel_spawner import barrel_spawner_pkg::*; #(
    parameter int              N_BARRELS    = 4,
    parameter int              FIRST_DELAY  = 30,
    parameter int              MIN_INTERVAL = 60,
    parameter int              RAND_BITS    = 6,
    parameter int              THROW_CYCLES = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         game_run,
    input  logic                         over,
    input  logic [2*N_BARRELS-1:0]       barrel_state,
    output logic [N_BARRELS-1:0]         start,
    output logic                         kong_throw,
    output logic [$clog2(N_BARRELS)-1:0] sel_idx,
    output logic [7:0]                   spawn_count,
    output logic [1:0]                   spawner_state
);
    localparam int CW = $clog2(MIN_INTERVAL + 2**RAND_BITS) + 1;
    localparam int SW = $clog2(N_BARRELS);
    sp_state_e          state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [N_BARRELS-1:0] start_n, free;
    logic               kong_n, any_free;
    logic [SW-1:0]      sel_n, pick;
    logic [7:0]         count_n;
    logic [LFSR_W-1:0]  lfsr;
    logic               lfsr_unused;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst(rst), .q(lfsr));
    assign lfsr_unused   = ^lfsr[LFSR_W-1:RAND_BITS];
    assign spawner_state = state;

    // registered start doubles as the just-fired mask: the launched barrel still reads INITIAL for one tick
    always_comb begin
        for (int i = 0; i < N_BARRELS; i++)
            free[i] = (barrel_state[2*i +: 2] == B_INITIAL) && !start[i];
        any_free = |free;
    end

    always_comb begin
        pick = '0;
        for (int i = N_BARRELS - 1; i >= 0; i--)
            if (free[i]) pick = SW'(i);
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        start_n = '0;
        kong_n  = kong_throw;
        sel_n   = sel_idx;
        count_n = spawn_count;
        if (over || !game_run) begin
            state_n = SP_IDLE;
            cnt_n   = '0;
            kong_n  = 1'b0;
            count_n = '0;
        end else begin
            case (state)
                SP_IDLE: begin
                    state_n = SP_WAIT;
                    cnt_n   = CW'(FIRST_DELAY);
                end
                SP_WAIT: begin
                    if (cnt != '0) cnt_n = cnt - CW'(1);
                    else if (any_free) begin
                        sel_n   = pick;
                        state_n = SP_THROW;
                        cnt_n   = CW'(THROW_CYCLES - 1);
                        kong_n  = 1'b1;
                    end
                end
                SP_THROW: begin
                    kong_n = 1'b1;
                    if (cnt != '0) cnt_n = cnt - CW'(1);
                    else begin
                        state_n = free[sel_idx] ? SP_RELEASE : SP_WAIT;
                        start_n[sel_idx] = free[sel_idx];
                        kong_n  = 1'b0;
                    end
                end
                default: begin
                    state_n = SP_WAIT;
                    count_n = spawn_count + 8'(spawn_count != 8'hFF);
                    cnt_n   = CW'(MIN_INTERVAL) + CW'(lfsr[RAND_BITS-1:0]);
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SP_IDLE;
            cnt         <= '0;
            start       <= '0;
            kong_throw  <= 1'b0;
            sel_idx     <= '0;
            spawn_count <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            start       <= start_n;
            kong_throw  <= kong_n;
            sel_idx     <= sel_n;
            spawn_count <= count_n;
        end
    end
endmodule

// File: tb/tb_barrel_spawner.sv
// tb_barrel_spawner: scoreboarded start-pulse timing/selection checks for barrel_spawner
module tb_barrel_spawner;
    typedef struct packed {
        logic [3:0] vec;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       game_run = 1'b0;
    logic       over = 1'b0;
    logic [7:0] barrel_state = '0;
    logic [3:0] start;
    logic       kong_throw;
    logic [1:0] sel_idx;
    logic [7:0] spawn_count;
    logic [1:0] spawner_state;

    int         n_vec = 0, n_bad = 0;
    int         cyc = 0, kong_len = 0, last_p = 0, auto_left = 0, e0 = 0, t0 = 0;
    bit         per_chk = 1'b0;
    logic [3:0] auto_vec = 4'b0001;
    logic [15:0] lfsr_m = 16'hACE1;
    exp_t       sb[$];

    barrel_spawner dut (
        .clk(clk), .rst(rst), .game_run(game_run), .over(over),
        .barrel_state(barrel_state), .start(start), .kong_throw(kong_throw),
        .sel_idx(sel_idx), .spawn_count(spawn_count), .spawner_state(spawner_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        lfsr_m <= rst ? 16'hACE1 : {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // monitor: pops expected pulses, checks kong_throw width and interval range
    always @(posedge clk) begin
        logic [3:0] busy;
        exp_t e;
        #1;
        if (kong_throw) kong_len++;
        else begin
            if (kong_len != 0 && start != 0) check("kong_len", kong_len, 16);
            kong_len = 0;
        end
        if (start != 0) begin
            for (int i = 0; i < 4; i++) busy[i] = barrel_state[2*i +: 2] != 2'b00;
            check("onehot", 32'($onehot(start)), 1);
            check("busy_start", {28'd0, start & busy}, 0);
            if (sb.size() == 0) check("unexp_start", {28'd0, start}, 0);
            else begin
                e = sb.pop_front();
                check("start_vec", {28'd0, start}, {28'd0, e.vec});
                check("start_cyc", cyc, e.cyc);
            end
            if (per_chk && last_p > 0)
                check("ival_rng", 32'((cyc - last_p - 18) >= 60 && (cyc - last_p - 18) <= 123), 1);
            last_p = per_chk ? cyc : 0;
            if (auto_left > 0) begin
                auto_left--;
                sb.push_back('{auto_vec, cyc + 78 + int'(lfsr_m[5:0])});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_sb(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic restart(input logic [7:0] bs);
        over = 1'b1;
        tick(1);
        over = 1'b0;
        barrel_state = bs;
        e0 = cyc + 1;
    endtask

    initial begin
        tick(3);
        check("rst_start", {28'd0, start}, 0);
        check("rst_kong", {31'd0, kong_throw}, 0);
        check("rst_sel", {30'd0, sel_idx}, 0);
        check("rst_count", {24'd0, spawn_count}, 0);
        check("rst_state", {30'd0, spawner_state}, 0);
        rst = 1'b0;
        tick(2);
        // first throw from game start
        game_run = 1'b1;
        e0 = cyc + 1;
        sb.push_back('{4'b0001, e0 + 47});
        wait_cyc(e0 + 31);
        check("t1_kong_on", {31'd0, kong_throw}, 1);
        check("t1_state", {30'd0, spawner_state}, 2);
        wait_sb(60);
        tick(1);
        check("t1_count", {24'd0, spawn_count}, 1);
        // lowest free index, then the next one once barrel 2 rolls
        restart(8'h05);
        auto_vec = 4'b1000;
        auto_left = 1;
        sb.push_back('{4'b0100, e0 + 47});
        wait_cyc(e0 + 47);
        check("t2_sel", {30'd0, sel_idx}, 2);
        barrel_state = 8'h15;
        wait_sb(300);
        check("t2_sel3", {30'd0, sel_idx}, 3);
        // stall with no free barrel
        restart(8'h55);
        wait_cyc(e0 + 40);
        check("t3_stall", {30'd0, spawner_state}, 1);
        check("t3_kong", {31'd0, kong_throw}, 0);
        barrel_state = 8'h51;
        t0 = cyc + 1;
        sb.push_back('{4'b0010, t0 + 16});
        wait_cyc(t0);
        check("t3_throw", {30'd0, spawner_state}, 2);
        check("t3_sel", {30'd0, sel_idx}, 1);
        wait_sb(40);
        tick(1);
        check("t3_count", {24'd0, spawn_count}, 1);
        // abort when barrel 0 leaves during THROW, then immediate retry on barrel 1
        restart(8'h00);
        wait_cyc(e0 + 35);
        barrel_state = 8'h01;
        sb.push_back('{4'b0010, e0 + 64});
        wait_cyc(e0 + 47);
        check("t4_abort", {30'd0, spawner_state}, 1);
        check("t4_kong", {31'd0, kong_throw}, 0);
        check("t4_count", {24'd0, spawn_count}, 0);
        wait_sb(40);
        tick(1);
        check("t4_count2", {24'd0, spawn_count}, 1);
        // over during THROW, then during RELEASE
        restart(8'h00);
        wait_cyc(e0 + 40);
        check("t5_kong", {31'd0, kong_throw}, 1);
        over = 1'b1;
        tick(1);
        check("t5_idle", {30'd0, spawner_state}, 0);
        check("t5_kong0", {31'd0, kong_throw}, 0);
        check("t5_count", {24'd0, spawn_count}, 0);
        over = 1'b0;
        e0 = cyc + 1;
        sb.push_back('{4'b0001, e0 + 47});
        wait_sb(60);
        over = 1'b1;
        tick(1);
        check("t5_rel_idle", {30'd0, spawner_state}, 0);
        check("t5_rel_start", {28'd0, start}, 0);
        check("t5_rel_count", {24'd0, spawn_count}, 0);
        // reset mid-WAIT, then 100 randomised intervals against the LFSR model
        over = 1'b0;
        tick(10);
        check("t6_wait", {30'd0, spawner_state}, 1);
        rst = 1'b1;
        tick(3);
        check("t6_rst_state", {30'd0, spawner_state}, 0);
        check("t6_rst_kong", {31'd0, kong_throw}, 0);
        per_chk = 1'b1;
        auto_vec = 4'b0001;
        auto_left = 100;
        rst = 1'b0;
        e0 = cyc + 1;
        sb.push_back('{4'b0001, e0 + 47});
        wait_sb(16000);
        tick(1);
        check("t6_count", {24'd0, spawn_count}, 101);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
